// File: rtl/reg_pipe_multi_channel_sum.sv
// Multi-lane register pipeline with valid/ready back-pressure and a lane-sum output.
// Each stage advances when it is empty or its successor advances, so bubbles collapse under stall.
module reg_pipe_multi_channel_sum #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned SUM_WIDTH  = 8,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   i_data,
    input  logic                             i_vld,
    output logic                             i_rd,
    output logic [SUM_WIDTH-1:0]             o_data,
    output logic                             o_vld,
    input  logic                             o_rd,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

    localparam int unsigned LaneW = CHANNELS * DATA_WIDTH;
    localparam int unsigned OccW  = $clog2(DEPTH + 1);
    localparam int unsigned BaseW = (DATA_WIDTH > SUM_WIDTH) ? DATA_WIDTH : SUM_WIDTH;
    localparam int unsigned AccW  = BaseW + $clog2(CHANNELS);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] en;
    logic [LaneW-1:0] d_q [DEPTH];
    logic [LaneW-1:0] d_d [DEPTH];
    logic             full_tail;
    logic [AccW-1:0]  acc;
    logic [OccW-1:0]  occ;

    // en[k] is high unless stage k and every stage after it is full while the consumer stalls.
    always_comb begin
        full_tail = 1'b1;
        en        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_tail = full_tail & v_q[k];
            en[k]     = o_rd | ~full_tail;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (en[0]) begin
            v_d[0] = i_vld;
            d_d[0] = i_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (en[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    // Sum is formed from held data regardless of valid, so it reads 0 after reset.
    always_comb begin
        acc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            acc = acc + AccW'(d_q[DEPTH-1][c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        if ((SATURATE != 0) && (acc > AccW'({SUM_WIDTH{1'b1}}))) begin
            o_data = '1;
        end else begin
            o_data = acc[SUM_WIDTH-1:0];
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OccW'(v_q[k]);
        end
    end

    assign i_rd      = en[0];
    assign o_vld     = v_q[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_reg_pipe_multi_channel_sum.sv
// Bench for reg_pipe_multi_channel_sum: default, saturating and deep/3-lane instances.
module tb_reg_pipe_multi_channel_sum;

    logic clk;
    logic rst;

    // default instance (wrap, DEPTH=2, CHANNELS=2)
    logic [15:0] d_data;
    logic        d_vld, d_ird, d_ovld, d_ord;
    logic [7:0]  d_odata;
    logic [1:0]  d_occ;

    // saturating instance
    logic [15:0] s_data;
    logic        s_vld, s_ird, s_ovld, s_ord;
    logic [7:0]  s_odata;
    logic [1:0]  s_occ;

    // deep instance (DEPTH=4, CHANNELS=3, SUM_WIDTH=10)
    logic [23:0] p_data;
    logic        p_vld, p_ird, p_ovld, p_ord;
    logic [9:0]  p_odata;
    logic [2:0]  p_occ;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [9:0] exp_q [$];

    reg_pipe_multi_channel_sum u_dut (
        .clk(clk), .rst(rst), .i_data(d_data), .i_vld(d_vld), .i_rd(d_ird),
        .o_data(d_odata), .o_vld(d_ovld), .o_rd(d_ord), .occupancy(d_occ)
    );

    reg_pipe_multi_channel_sum #(.SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .i_data(s_data), .i_vld(s_vld), .i_rd(s_ird),
        .o_data(s_odata), .o_vld(s_ovld), .o_rd(s_ord), .occupancy(s_occ)
    );

    reg_pipe_multi_channel_sum #(
        .DATA_WIDTH(8), .CHANNELS(3), .DEPTH(4), .SUM_WIDTH(10), .SATURATE(0)
    ) u_deep (
        .clk(clk), .rst(rst), .i_data(p_data), .i_vld(p_vld), .i_rd(p_ird),
        .o_data(p_odata), .o_vld(p_ovld), .o_rd(p_ord), .occupancy(p_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int         sel;
        logic       vld;
        logic [7:0] l1;
        logic [7:0] l0;
        logic       exp_vld;
        logic [7:0] exp_data;
        int         exp_occ;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] deep_sum(input logic [23:0] w);
        return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]);
    endfunction

    function automatic logic [23:0] deep_word(input int k);
        logic [7:0] a, b, c;
        a = 8'(k * 7);
        b = 8'(k + 1);
        c = 8'(255 - k);
        return {a, b, c};
    endfunction

    // One cycle on the deep instance; scoreboard tracks transfers that happen at the next edge.
    task automatic deep_cycle(input logic vld, input logic [23:0] w, input logic ord);
        @(posedge clk);
        #1;
        p_vld  = vld;
        p_data = w;
        p_ord  = ord;
        @(negedge clk);
        if (p_vld && p_ird) exp_q.push_back(deep_sum(w));
        if (p_ovld && p_ord) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL deep_spurious: got %0h expected no output", p_odata);
            end else begin
                check("deep_order", 32'(p_odata), 32'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1'b1, 8'h03, 8'h05, 1'b0, 8'h00, 0};
        vecs[1]  = '{0, 1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 1};
        vecs[2]  = '{0, 1'b1, 8'hFF, 8'h02, 1'b1, 8'h08, 2};
        vecs[3]  = '{0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 2};
        vecs[4]  = '{0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1};
        vecs[5]  = '{0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0};
        vecs[6]  = '{1, 1'b1, 8'hFF, 8'h02, 1'b0, 8'h00, 0};
        vecs[7]  = '{1, 1'b1, 8'h7F, 8'h80, 1'b0, 8'h00, 1};
        vecs[8]  = '{1, 1'b1, 8'h01, 8'h02, 1'b1, 8'hFF, 2};
        vecs[9]  = '{1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 2};
        vecs[10] = '{1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1};
        vecs[11] = '{1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0};

        rst = 1'b1;
        d_data = '0; d_vld = 1'b0; d_ord = 1'b1;
        s_data = '0; s_vld = 1'b0; s_ord = 1'b1;
        p_data = '0; p_vld = 1'b0; p_ord = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_d_vld", 32'(d_ovld), 0);
        check("rst_d_data", 32'(d_odata), 0);
        check("rst_d_occ", 32'(d_occ), 0);
        check("rst_d_ird", 32'(d_ird), 1);
        check("rst_s_vld", 32'(s_ovld), 0);
        check("rst_p_occ", 32'(p_occ), 0);
        check("rst_p_ird", 32'(p_ird), 1);

        // streaming (wrap) and saturation tables
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            d_vld = 1'b0; d_data = '0;
            s_vld = 1'b0; s_data = '0;
            if (vecs[i].sel == 0) begin
                d_vld  = vecs[i].vld;
                d_data = {vecs[i].l1, vecs[i].l0};
            end else begin
                s_vld  = vecs[i].vld;
                s_data = {vecs[i].l1, vecs[i].l0};
            end
            @(negedge clk);
            if (vecs[i].sel == 0) begin
                check($sformatf("vec%0d_vld", i), 32'(d_ovld), 32'(vecs[i].exp_vld));
                check($sformatf("vec%0d_data", i), 32'(d_odata), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_occ", i), 32'(d_occ), 32'(vecs[i].exp_occ));
                check($sformatf("vec%0d_ird", i), 32'(d_ird), 1);
            end else begin
                check($sformatf("vec%0d_vld", i), 32'(s_ovld), 32'(vecs[i].exp_vld));
                check($sformatf("vec%0d_data", i), 32'(s_odata), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_occ", i), 32'(s_occ), 32'(vecs[i].exp_occ));
                check($sformatf("vec%0d_ird", i), 32'(s_ird), 1);
            end
        end

        // back-pressure with a gap: W1 _ W2 W3 W4, o_rd low
        deep_cycle(1'b1, {8'h01, 8'h02, 8'h03}, 1'b0);
        deep_cycle(1'b0, 24'h0, 1'b0);
        deep_cycle(1'b1, {8'h10, 8'h20, 8'h30}, 1'b0);
        deep_cycle(1'b1, {8'hFF, 8'hFF, 8'hFF}, 1'b0);
        deep_cycle(1'b1, {8'h80, 8'h00, 8'h01}, 1'b0);
        check("bp_occ_before_full", 32'(p_occ), 3);
        check("bp_ird_before_full", 32'(p_ird), 1);
        for (int i = 0; i < 3; i++) begin
            deep_cycle(1'b0, 24'h0, 1'b0);
            check("bp_full_occ", 32'(p_occ), 4);
            check("bp_full_ird", 32'(p_ird), 0);
            check("bp_hold_vld", 32'(p_ovld), 1);
            check("bp_hold_data", 32'(p_odata), 32'h006);
        end
        n_out = 0;
        for (int i = 0; i < 8; i++) deep_cycle(1'b0, 24'h0, 1'b1);
        check("bp_out_count", 32'(n_out), 4);
        check("bp_queue_empty", 32'(exp_q.size()), 0);

        // full pipe with simultaneous input and output
        n_out = 0;
        for (int k = 0; k < 4; k++) deep_cycle(1'b1, deep_word(k), 1'b0);
        for (int k = 4; k < 14; k++) begin
            deep_cycle(1'b1, deep_word(k), 1'b1);
            check("full_occ", 32'(p_occ), 4);
            check("full_ird", 32'(p_ird), 1);
        end
        for (int i = 0; i < 10; i++) deep_cycle(1'b0, 24'h0, 1'b1);
        check("full_out_count", 32'(n_out), 14);
        check("full_queue_empty", 32'(exp_q.size()), 0);

        // reset with two words in flight and a third presented during reset
        deep_cycle(1'b1, {8'h11, 8'h22, 8'h33}, 1'b1);
        deep_cycle(1'b1, {8'h44, 8'h55, 8'h66}, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p_vld = 1'b1;
        p_data = {8'h77, 8'h88, 8'h99};
        @(posedge clk);
        #1;
        rst = 1'b0;
        p_vld = 1'b0;
        p_data = '0;
        exp_q.delete();
        @(negedge clk);
        check("rstmid_vld", 32'(p_ovld), 0);
        check("rstmid_occ", 32'(p_occ), 0);
        check("rstmid_data", 32'(p_odata), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rstmid_no_emit", 32'(p_ovld), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
